// File: rtl/servant_trace_pkg.sv
// rtl/servant_trace_pkg.sv - shared constants for the servant instruction-trace buffer
package servant_trace_pkg;

   localparam logic [1:0] MODE_ALL  = 2'd0;
   localparam logic [1:0] MODE_JUMP = 2'd1;
   localparam logic [1:0] MODE_IRQ  = 2'd2;
   localparam logic [1:0] MODE_OFF  = 2'd3;

   // Flag bit offsets above the pc field; the timestamp sits above the flags.
   localparam int REC_IRQ_OFS  = 0;
   localparam int REC_JUMP_OFS = 1;
   localparam int REC_MRET_OFS = 2;
   localparam int REC_FLAG_W   = 3;

   localparam logic [0:0] LAT_IDLE  = 1'b0;
   localparam logic [0:0] LAT_COUNT = 1'b1;

   function automatic int rec_width(input int aw, input int ts_w);
      return ts_w + aw + REC_FLAG_W;
   endfunction

endpackage

// File: rtl/servant_trace_fifo.sv
// rtl/servant_trace_fifo.sv - synchronous FIFO with a registered head word
module servant_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int IW = $clog2(DEPTH);

   logic [IW:0]      wr_ptr_q, wr_ptr_d;
   logic [IW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   always_comb begin
      level   = wr_ptr_q - rd_ptr_q;
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      wr_ptr_d = wr_ptr_q + {{IW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{IW{1'b0}}, pop_ok};
      // A push landing in the slot that becomes the head must bypass the array.
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
         head_d = wr_data;
      end else begin
         head_d = mem_q[rd_ptr_d[IW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[IW-1:0]] <= wr_data;
      end
   end

   assign head = head_q;

endmodule

// File: rtl/servant_trace_buf.sv
// rtl/servant_trace_buf.sv - filtered, timestamped trace capture with irq-to-trap latency meter
module servant_trace_buf
   import servant_trace_pkg::*;
#(
   parameter int            AW       = 32,
   parameter int            DEPTH    = 16,
   parameter int            TS_W     = 16,
   parameter int            LAT_W    = 12,
   parameter int            DROP_W   = 8,
   parameter logic [AW-1:0] TRAP_VEC = '0
) (
   input  logic                        wb_clk,
   input  logic                        wb_rst,
   input  logic [AW-1:0]               pc_adr,
   input  logic                        pc_vld,
   input  logic                        isjump,
   input  logic                        timer_irq,
   input  logic                        mret,
   input  logic [1:0]                  mode,
   output logic [TS_W+AW+2:0]          rd_data,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic [$clog2(DEPTH):0]      level,
   output logic [DROP_W-1:0]           drop_cnt,
   output logic [LAT_W-1:0]            irq_lat,
   output logic                        irq_lat_vld
);

   localparam int REC_W = rec_width(AW, TS_W);

   logic [TS_W-1:0]   ts_q, ts_d;
   logic              irq_prev_q, irq_prev_d;
   logic [0:0]        lat_st_q, lat_st_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [LAT_W-1:0]  irq_lat_q, irq_lat_d;
   logic              irq_lat_vld_q, irq_lat_vld_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              keep, cand, irq_rise, trap_hit;
   logic              fifo_full, fifo_empty;
   logic [REC_W-1:0]  rec;

   always_comb begin
      ts_d = ts_q + TS_W'(1);

      case (mode)
         MODE_ALL:  keep = 1'b1;
         MODE_JUMP: keep = isjump | mret;
         MODE_IRQ:  keep = (lat_st_q == LAT_COUNT) | timer_irq;
         default:   keep = 1'b0;
      endcase
      cand = pc_vld & keep;

      rec                        = '0;
      rec[AW-1:0]                = pc_adr;
      rec[AW+REC_IRQ_OFS]        = timer_irq;
      rec[AW+REC_JUMP_OFS]       = isjump;
      rec[AW+REC_MRET_OFS]       = mret;
      rec[REC_W-1 -: TS_W]       = ts_q;

      // Full implies non-empty, so rd_ready alone tells whether a slot frees up.
      drop_d = drop_q;
      if (cand && fifo_full && !rd_ready && (drop_q != '1)) begin
         drop_d = drop_q + DROP_W'(1);
      end

      irq_prev_d    = timer_irq;
      irq_rise      = timer_irq & ~irq_prev_q;
      trap_hit      = pc_vld & (pc_adr == TRAP_VEC);
      lat_st_d      = lat_st_q;
      lat_cnt_d     = lat_cnt_q;
      irq_lat_d     = irq_lat_q;
      irq_lat_vld_d = 1'b0;
      case (lat_st_q)
         LAT_IDLE: begin
            if (irq_rise) begin
               lat_st_d  = LAT_COUNT;
               lat_cnt_d = LAT_W'(1);
            end
         end
         LAT_COUNT: begin
            if (trap_hit) begin
               lat_st_d      = LAT_IDLE;
               irq_lat_d     = lat_cnt_q;
               irq_lat_vld_d = 1'b1;
            end else if (lat_cnt_q != '1) begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         default: lat_st_d = LAT_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         ts_q          <= '0;
         irq_prev_q    <= 1'b0;
         lat_st_q      <= LAT_IDLE;
         lat_cnt_q     <= '0;
         irq_lat_q     <= '0;
         irq_lat_vld_q <= 1'b0;
         drop_q        <= '0;
      end else begin
         ts_q          <= ts_d;
         irq_prev_q    <= irq_prev_d;
         lat_st_q      <= lat_st_d;
         lat_cnt_q     <= lat_cnt_d;
         irq_lat_q     <= irq_lat_d;
         irq_lat_vld_q <= irq_lat_vld_d;
         drop_q        <= drop_d;
      end
   end

   servant_trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (wb_clk),
      .rst     (wb_rst),
      .push    (cand),
      .wr_data (rec),
      .pop     (rd_ready),
      .head    (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign rd_valid    = ~fifo_empty;
   assign drop_cnt    = drop_q;
   assign irq_lat     = irq_lat_q;
   assign irq_lat_vld = irq_lat_vld_q;

endmodule
